// File: rtl/uart_line_decoder_if.sv
// Byte stream handshake between the UART line decoder and its consumer.
// The decoder drives data/valid. The consumer drives ready.
`timescale 1ns/1ps
interface uart_line_decoder_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_line_decoder.sv
// 8N1 UART receive decoder.
// - The serial line is synchronized, framed by a counter-driven FSM and
//   mid-bit sampled.
// - Completed bytes land in a small first-word-fall-through FIFO that is read
//   over a valid/ready port.
`timescale 1ns/1ps
module uart_line_decoder #(
    parameter int unsigned FREQ_CLK   = 100000000,
    parameter int unsigned TX_SPEED   = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_line_in,
    output logic                       o_frame_error,
    output logic                       o_overflow,
    output logic                       o_busy,
    uart_line_decoder_if.master        rx
);

    localparam int unsigned BIT_CYCLES = FREQ_CLK / TX_SPEED;
    localparam int unsigned HALF       = BIT_CYCLES / 2;
    localparam int          CW         = $clog2(BIT_CYCLES);
    localparam int          PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          NW         = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] C_BIT_M1  = CW'(BIT_CYCLES - 1);
    localparam logic [NW-1:0] C_DEPTH   = NW'(FIFO_DEPTH);
    localparam logic [PW-1:0] C_PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_line_s;

    // Two-flop synchronizer. Both flops reset to the idle (high) level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_line_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line_s = r_sync2;

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_bitn;
    logic [7:0]     r_shift;
    logic           r_push;
    logic [7:0]     r_push_data;
    logic           r_frame_error;
    logic           r_busy;

    // Frame recovery.
    // - The counter restarts on every state entry and on every sample.
    // - r_push hands a good byte to the FIFO one cycle after the stop sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bitn        <= '0;
            r_shift       <= '0;
            r_push        <= 1'b0;
            r_push_data   <= '0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_push        <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_line_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF_M1) begin
                        r_cnt <= '0;
                        if (w_line_s) begin
                            // Start bit did not survive to mid-bit: a glitch.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_bitn  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_BIT_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_line_s, r_shift[7:1]};
                        if (r_bitn == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bitn <= r_bitn + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == C_BIT_M1) begin
                        r_cnt <= '0;
                        if (w_line_s) begin
                            // Leave at mid-stop-bit so the next start edge is caught.
                            r_push      <= 1'b1;
                            r_push_data <= r_shift;
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (w_line_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FWFT byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [NW-1:0]  r_count;
    logic [7:0]     r_data;
    logic           r_valid;
    logic           r_overflow;

    logic           w_pop;
    logic           w_full;
    logic           w_push;
    logic           w_drop;
    logic [PW-1:0]  w_rd_next;
    logic [NW-1:0]  w_count_next;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == C_PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO still takes a byte when the consumer frees a slot in the same cycle.
    assign w_pop        = r_valid & rx.ready;
    assign w_full       = (r_count == C_DEPTH);
    assign w_push       = r_push & (~w_full | w_pop);
    assign w_drop       = r_push & w_full & ~w_pop;
    assign w_rd_next    = w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;
    assign w_count_next = r_count + NW'(w_push) - NW'(w_pop);

    // Storage array. No reset is needed because r_count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    // Pointer, count and registered head-of-FIFO output.
    // - A byte written into the slot that becomes the head bypasses the array.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_count_next;
            r_valid    <= (w_count_next != '0);
            r_overflow <= w_drop;
            r_data     <= (w_push && (r_wr_ptr == w_rd_next)) ? r_push_data
                                                              : r_mem[w_rd_next];
        end
    end

    assign rx.data       = r_data;
    assign rx.valid      = r_valid;
    assign o_frame_error = r_frame_error;
    assign o_overflow    = r_overflow;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_uart_line_decoder.sv
// Bench for uart_line_decoder: directed scenarios plus a randomized byte
// stream checked against a queue-based reference of the bytes put on the line.
`timescale 1ns/1ps
module tb_uart_line_decoder;

    localparam int FREQ  = 3200000;
    localparam int SPEED = 100000;
    localparam int BC    = FREQ / SPEED;
    localparam int HALF  = BC / 2;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic line = 1'b1;
    logic rdy  = 1'b0;
    logic fe, ov, busy;

    uart_line_decoder_if u_if ();
    assign u_if.ready = rdy;

    uart_line_decoder #(
        .FREQ_CLK   (FREQ),
        .TX_SPEED   (SPEED),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_line_in     (line),
        .o_frame_error (fe),
        .o_overflow    (ov),
        .o_busy        (busy),
        .rx            (u_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer: logs every accepted byte and counts flag/valid cycles.
    logic [7:0] got_q [$];
    int   fe_cnt   = 0;
    int   ov_cnt   = 0;
    int   vld_cnt  = 0;
    int   vld_rise = -1;
    logic vld_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && u_if.valid && rdy) got_q.push_back(u_if.data);
        if (fe) fe_cnt++;
        if (ov) ov_cnt++;
        if (u_if.valid) vld_cnt++;
        if (u_if.valid && !vld_prev) vld_rise = cyc;
        vld_prev = u_if.valid;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    int e0      = 0;
    int pop_off = -1;
    bit rdy_rand = 1'b0;

    // One clock, leaving us just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) rdy = 1'($urandom_range(0, 1));
        else if (pop_off >= 0) rdy = (cyc == e0 + pop_off);
    endtask

    // Drive the first ncyc cycles of an 8N1 frame; e0 = edge capturing the start bit.
    task automatic line_bits(input logic [7:0] b, input bit stop_ok, input int ncyc);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        e0 = cyc + 1;
        for (int i = 0; i < ncyc; i++) begin
            line = fr[i / BC];
            tick();
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        line_bits(b, stop_ok, 10 * BC);
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop_one();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    logic [7:0] exp_q [$];

    initial begin
        int b0, f0, o0, v0, nbad, gap;
        logic [7:0] rb;
        bit ok;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_valid", 32'(u_if.valid), 32'd0);
        chk("rst_data",  32'(u_if.data),  32'h00);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_fe",    32'(fe),         32'd0);
        chk("rst_ov",    32'(ov),         32'd0);
        tick();

        // Single byte with consumer always ready.
        rdy = 1'b1;
        b0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt; v0 = vld_cnt;
        send(8'hAB, 1'b1);
        idle(2 * BC);
        chk("single_latency", 32'(vld_rise - e0), 32'(3 + HALF + 9 * BC));
        chk("single_count",   32'(got_q.size() - b0), 32'd1);
        chk("single_byte",    32'(got_q[b0]), 32'hAB);
        chk("single_vcycles", 32'(vld_cnt - v0), 32'd1);
        chk("single_fe",      32'(fe_cnt - f0), 32'd0);
        chk("single_ov",      32'(ov_cnt - o0), 32'd0);

        // Back-to-back frames, consumer stalled.
        rdy = 1'b0;
        b0 = got_q.size();
        send(8'hAB, 1'b1);
        send(8'hCD, 1'b1);
        idle(BC);
        chk("b2b_valid0", 32'(u_if.valid), 32'd1);
        chk("b2b_head0",  32'(u_if.data),  32'hAB);
        pop_one();
        chk("b2b_valid1", 32'(u_if.valid), 32'd1);
        chk("b2b_head1",  32'(u_if.data),  32'hCD);
        pop_one();
        chk("b2b_empty",  32'(u_if.valid), 32'd0);
        chk("b2b_pop0",   32'(got_q[b0]),     32'hAB);
        chk("b2b_pop1",   32'(got_q[b0 + 1]), 32'hCD);

        // Glitch shorter than half a bit.
        f0 = fe_cnt; o0 = ov_cnt; b0 = got_q.size();
        line = 1'b0;
        e0 = cyc + 1;
        for (int i = 0; i < HALF / 2; i++) tick();
        line = 1'b1;
        while (cyc < e0 + 1 + HALF) tick();
        chk("glitch_busy_before", 32'(busy), 32'd1);
        tick();
        chk("glitch_busy_after",  32'(busy), 32'd0);
        idle(BC);
        chk("glitch_fe",    32'(fe_cnt - f0), 32'd0);
        chk("glitch_ov",    32'(ov_cnt - o0), 32'd0);
        chk("glitch_valid", 32'(u_if.valid), 32'd0);

        // Frame error followed by a long break.
        f0 = fe_cnt;
        send(8'h55, 1'b0);
        for (int i = 0; i < 4 * BC; i++) tick();
        chk("break_busy",  32'(busy), 32'd1);
        chk("break_fe",    32'(fe_cnt - f0), 32'd1);
        chk("break_valid", 32'(u_if.valid), 32'd0);
        line = 1'b1;
        repeat (4) tick();
        chk("break_release", 32'(busy), 32'd0);
        chk("break_fe_once", 32'(fe_cnt - f0), 32'd1);
        idle(BC);

        // Overflow on the fifth byte.
        rdy = 1'b0;
        o0 = ov_cnt;
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b1);
        idle(BC);
        chk("ovf_pulses", 32'(ov_cnt - o0), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_valid", 32'(u_if.valid), 32'd1);
            chk("ovf_order", 32'(u_if.data), 32'(k));
            pop_one();
        end
        chk("ovf_empty", 32'(u_if.valid), 32'd0);

        // Push into a full FIFO while popping in the same cycle.
        for (int v = 1; v <= 4; v++) send(8'(v), 1'b1);
        idle(4);
        o0 = ov_cnt; b0 = got_q.size();
        pop_off = 2 + HALF + 9 * BC;
        send(8'h5A, 1'b1);
        pop_off = -1;
        rdy = 1'b0;
        idle(BC);
        chk("full_pp_ov",   32'(ov_cnt - o0), 32'd0);
        chk("full_pp_npop", 32'(got_q.size() - b0), 32'd1);
        chk("full_pp_pop",  32'(got_q[b0]), 32'h01);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h5A};
        foreach (exp_q[k]) begin
            chk("full_pp_valid", 32'(u_if.valid), 32'd1);
            chk("full_pp_order", 32'(u_if.data), 32'(exp_q[k]));
            pop_one();
        end
        chk("full_pp_empty", 32'(u_if.valid), 32'd0);

        // Reset in data bit 4 with a byte already queued.
        send(8'h11, 1'b1);
        idle(4);
        chk("mrst_pre_valid", 32'(u_if.valid), 32'd1);
        line_bits(8'hAB, 1'b1, 5 * BC + BC / 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 32'(u_if.valid), 32'd0);
        chk("mrst_data",  32'(u_if.data),  32'h00);
        chk("mrst_busy",  32'(busy),       32'd0);
        chk("mrst_fe",    32'(fe),         32'd0);
        chk("mrst_ov",    32'(ov),         32'd0);
        idle(2 * BC);
        rdy = 1'b1;
        b0 = got_q.size();
        send(8'hCD, 1'b1);
        idle(2 * BC);
        chk("mrst_count", 32'(got_q.size() - b0), 32'd1);
        chk("mrst_byte",  32'(got_q[b0]), 32'hCD);

        // Randomized stream: random bytes, gaps, bad stop bits and ready.
        exp_q.delete();
        nbad = 0;
        f0 = fe_cnt; o0 = ov_cnt; b0 = got_q.size();
        rdy_rand = 1'b1;
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send(rb, ok);
            if (ok) begin
                exp_q.push_back(rb);
                gap = int'($urandom_range(0, BC));
            end else begin
                nbad++;
                gap = int'($urandom_range(4, BC));
            end
            idle(gap);
        end
        rdy_rand = 1'b0;
        rdy = 1'b1;
        idle(4 * BC);
        chk("rand_count", 32'(got_q.size() - b0), 32'(exp_q.size()));
        foreach (exp_q[k]) chk("rand_byte", 32'(got_q[b0 + k]), 32'(exp_q[k]));
        chk("rand_fe", 32'(fe_cnt - f0), 32'(nbad));
        chk("rand_ov", 32'(ov_cnt - o0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
